// File: rtl/bcd_down_cnt8.sv
// Loadable 2-digit BCD down-counter/timer (99..00) with start/stop, done level and borrow-out pulse.
// Optional macro BCD_DOWN_AUTO_RELOAD_EN: reload the preset after reaching 00 and keep running.
module bcd_down_cnt8 (
   input  logic       clk,
   input  logic       R,
   input  logic       ld,
   input  logic [7:0] DIN,
   input  logic       start,
   input  logic       stop,
   input  logic       ce,
   output logic [7:0] DHL,
   output logic [3:0] cd_DH,
   output logic [3:0] cd_DL,
   output logic       busy,
   output logic       done,
   output logic       BO,
   output logic       err
);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t     st, st_nx;
   logic [3:0] dh, dl, dh_nx, dl_nx;
   logic [3:0] ph, pl;
   logic       bo, bo_nx, er, er_nx;
   logic       zero, one;

`ifdef BCD_DOWN_AUTO_RELOAD_EN
   logic [3:0] rh, rl, rh_nx, rl_nx;
`endif

   // Non-BCD preset digits are clamped to 9
   always_comb begin
      ph = (DIN[7:4] > 4'd9) ? 4'd9 : DIN[7:4];
      pl = (DIN[3:0] > 4'd9) ? 4'd9 : DIN[3:0];
   end

   assign zero = (dh == 4'd0) && (dl == 4'd0);
   assign one  = (dh == 4'd0) && (dl == 4'd1);

   always_comb begin
      st_nx = st;
      dh_nx = dh;
      dl_nx = dl;
      bo_nx = 1'b0;
      er_nx = er;
`ifdef BCD_DOWN_AUTO_RELOAD_EN
      rh_nx = rh;
      rl_nx = rl;
`endif
      if (ld) begin
         dh_nx = ph;
         dl_nx = pl;
         er_nx = (DIN[7:4] > 4'd9) || (DIN[3:0] > 4'd9);
         st_nx = IDLE;
`ifdef BCD_DOWN_AUTO_RELOAD_EN
         rh_nx = ph;
         rl_nx = pl;
`endif
      end else if (stop && st == RUN) begin
         st_nx = IDLE;
      end else if (start && st == IDLE) begin
         st_nx = zero ? DONE : RUN;
      end else if (ce && st == RUN) begin
`ifdef BCD_DOWN_AUTO_RELOAD_EN
         if (zero) begin
            dh_nx = rh;
            dl_nx = rl;
         end else
`endif
         if (dl == 4'd0) begin
            dl_nx = 4'd9;
            dh_nx = dh - 4'd1;
         end else begin
            dl_nx = dl - 4'd1;
         end
         if (one) begin
            bo_nx = 1'b1;
`ifndef BCD_DOWN_AUTO_RELOAD_EN
            st_nx = DONE;
`endif
         end
      end
   end

   always_ff @(posedge clk or posedge R) begin
      if (R) begin
         st <= IDLE;
         dh <= '0;
         dl <= '0;
         bo <= 1'b0;
         er <= 1'b0;
`ifdef BCD_DOWN_AUTO_RELOAD_EN
         rh <= '0;
         rl <= '0;
`endif
      end else begin
         st <= st_nx;
         dh <= dh_nx;
         dl <= dl_nx;
         bo <= bo_nx;
         er <= er_nx;
`ifdef BCD_DOWN_AUTO_RELOAD_EN
         rh <= rh_nx;
         rl <= rl_nx;
`endif
      end
   end

   assign cd_DH = dh;
   assign cd_DL = dl;
   assign DHL   = {dh, dl};
   assign busy  = (st == RUN);
   assign done  = (st == DONE);
   assign BO    = bo;
   assign err   = er;

endmodule

// File: tb/tb_bcd_down_cnt8.sv
// Directed bench for bcd_down_cnt8: expected outputs queued per step, checked one clock later.
module tb_bcd_down_cnt8;

   logic       clk = 1'b0;
   logic       R = 1'b1;
   logic       ld = 1'b0;
   logic [7:0] DIN = '0;
   logic       start = 1'b0;
   logic       stop = 1'b0;
   logic       ce = 1'b0;
   logic [7:0] DHL;
   logic [3:0] cd_DH, cd_DL;
   logic       busy, done, BO, err;

   int unsigned vectors = 0;
   int unsigned miscompares = 0;

   typedef struct {
      string      tag;
      logic [19:0] v;
   } exp_t;

   exp_t sb[$];

   bcd_down_cnt8 dut (
      .clk(clk), .R(R), .ld(ld), .DIN(DIN), .start(start), .stop(stop), .ce(ce),
      .DHL(DHL), .cd_DH(cd_DH), .cd_DL(cd_DL), .busy(busy), .done(done), .BO(BO), .err(err)
   );

   always #5 clk = ~clk;

   task automatic push(input string tag, input logic [7:0] d, input logic b, input logic dn,
                       input logic bo, input logic e);
      exp_t x;
      x.tag = tag;
      x.v   = {d, d[7:4], d[3:0], b, dn, bo, e};
      sb.push_back(x);
   endtask

   task automatic check();
      exp_t x;
      logic [19:0] obs;
      x   = sb.pop_front();
      obs = {DHL, cd_DH, cd_DL, busy, done, BO, err};
      vectors++;
      assert (obs === x.v) else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h", x.tag, obs, x.v);
      end
   endtask

   task automatic step(input string tag, input logic l, input logic [7:0] din, input logic sa,
                       input logic so, input logic c, input logic [7:0] d, input logic b,
                       input logic dn, input logic bo, input logic e);
      @(negedge clk);
      ld = l; DIN = din; start = sa; stop = so; ce = c;
      push(tag, d, b, dn, bo, e);
      @(posedge clk);
      #1 check();
   endtask

   function automatic logic [7:0] bcd(input int unsigned v);
      logic [3:0] h, l;
      h = 4'(v / 10);
      l = 4'(v % 10);
      return {h, l};
   endfunction

   initial begin
      // reset state, observed without waiting for an edge
      #2;
      push("reset", 8'h00, 0, 0, 0, 0);
      check();
      @(negedge clk);
      R = 1'b0;

      // invalid load and clamping
      step("ld_A3", 1, 8'hA3, 0, 0, 0, 8'h93, 0, 0, 0, 1);
      step("ld_45", 1, 8'h45, 0, 0, 0, 8'h45, 0, 0, 0, 0);
      step("ld_FF", 1, 8'hFF, 0, 0, 0, 8'h99, 0, 0, 0, 1);
      step("ce_idle", 0, 8'h00, 0, 0, 1, 8'h99, 0, 0, 0, 1);

      // borrow and ce gating
      step("ld_20", 1, 8'h20, 0, 0, 0, 8'h20, 0, 0, 0, 0);
      step("start20", 0, 8'h00, 1, 0, 0, 8'h20, 1, 0, 0, 0);
      step("borrow", 0, 8'h00, 0, 0, 1, 8'h19, 1, 0, 0, 0);
      step("ce_hold", 0, 8'h00, 0, 0, 0, 8'h19, 1, 0, 0, 0);
      step("dec18", 0, 8'h00, 1, 0, 1, 8'h18, 1, 0, 0, 0);
      step("stop18", 0, 8'h00, 0, 1, 1, 8'h18, 0, 0, 0, 0);

`ifdef BCD_DOWN_AUTO_RELOAD_EN
      step("ld_03", 1, 8'h03, 0, 0, 0, 8'h03, 0, 0, 0, 0);
      step("start03", 0, 8'h00, 1, 0, 0, 8'h03, 1, 0, 0, 0);
      for (int i = 1; i <= 8; i++) begin
         int unsigned v;
         v = (i % 4 == 0) ? 0 : 3 - (i % 4);
         if (i % 4 == 0) v = 0;
         else if (i % 4 == 1) v = 2;
         else if (i % 4 == 2) v = 1;
         else v = 0;
         if (i == 4 || i == 8) v = 3;
         step("reload", 0, 8'h00, 0, 0, 1, bcd(v), 1, 0, (i == 3 || i == 7), 0);
      end
      step("ar_stop", 0, 8'h00, 0, 1, 1, 8'h03, 0, 0, 0, 0);
      step("ld_00", 1, 8'h00, 0, 0, 0, 8'h00, 0, 0, 0, 0);
      step("start00", 0, 8'h00, 1, 0, 1, 8'h00, 0, 1, 0, 0);
`else
      // basic countdown 12 -> 00
      step("ld_12", 1, 8'h12, 0, 0, 0, 8'h12, 0, 0, 0, 0);
      step("start12", 0, 8'h00, 1, 0, 0, 8'h12, 1, 0, 0, 0);
      for (int i = 1; i <= 12; i++)
         step("count", 0, 8'h00, 0, 0, 1, bcd(12 - i), (i != 12), (i == 12), (i == 12), 0);
      step("done_hold", 0, 8'h00, 0, 0, 1, 8'h00, 0, 1, 0, 0);
      step("start_done", 0, 8'h00, 1, 0, 1, 8'h00, 0, 1, 0, 0);

      // stop/resume, then zero start
      step("ld_05", 1, 8'h05, 0, 0, 0, 8'h05, 0, 0, 0, 0);
      step("start05", 0, 8'h00, 1, 0, 0, 8'h05, 1, 0, 0, 0);
      step("dec04", 0, 8'h00, 0, 0, 1, 8'h04, 1, 0, 0, 0);
      step("dec03", 0, 8'h00, 0, 0, 1, 8'h03, 1, 0, 0, 0);
      step("stop03", 0, 8'h00, 0, 1, 1, 8'h03, 0, 0, 0, 0);
      step("idle03", 0, 8'h00, 0, 0, 1, 8'h03, 0, 0, 0, 0);
      step("resume", 0, 8'h00, 1, 0, 1, 8'h03, 1, 0, 0, 0);
      step("dec02", 0, 8'h00, 0, 0, 1, 8'h02, 1, 0, 0, 0);
      step("dec01", 0, 8'h00, 0, 0, 1, 8'h01, 1, 0, 0, 0);
      step("dec00", 0, 8'h00, 0, 0, 1, 8'h00, 0, 1, 1, 0);
      step("ld_00", 1, 8'h00, 0, 0, 0, 8'h00, 0, 0, 0, 0);
      step("start00", 0, 8'h00, 1, 0, 1, 8'h00, 0, 1, 0, 0);

      // load colliding with arrival at 00
      step("ld_02", 1, 8'h02, 0, 0, 0, 8'h02, 0, 0, 0, 0);
      step("start02", 0, 8'h00, 1, 0, 0, 8'h02, 1, 0, 0, 0);
      step("dec01b", 0, 8'h00, 0, 0, 1, 8'h01, 1, 0, 0, 0);
      step("ld_wins", 1, 8'h37, 0, 0, 1, 8'h37, 0, 0, 0, 0);
`endif

      // reset mid-run, observed before the next edge
      step("ld_50", 1, 8'h50, 0, 0, 0, 8'h50, 0, 0, 0, 0);
      step("start50", 0, 8'h00, 1, 0, 0, 8'h50, 1, 0, 0, 0);
      step("dec49", 0, 8'h00, 0, 0, 1, 8'h49, 1, 0, 0, 0);
      @(negedge clk);
      R = 1'b1;
      #1;
      push("reset_run", 8'h00, 0, 0, 0, 0);
      check();
      @(negedge clk);
      R = 1'b0;
      step("post_reset", 0, 8'h00, 0, 0, 1, 8'h00, 0, 0, 0, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
